accel_tilt_cordic: RTL and testbench

//   Upstream stage of the Kalman attitude core. Converts one raw accelerometer sample (ax, ay, az)

---
 rtl/accel_tilt_cordic.sv | 120 ++++++++++++
 tb/tb_accel_tilt_cordic.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/accel_tilt_cordic.sv
// accel_tilt_cordic: pitch/roll tilt angles from one accel sample using a shared iterative CORDIC vectoring engine
module accel_tilt_cordic #(
    parameter int DATA_W = 16,
    parameter int ITER   = 14,
    parameter int INT_W  = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] ax,
    input  logic signed [DATA_W-1:0] ay,
    input  logic signed [DATA_W-1:0] az,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] theta_acc,
    output logic signed [DATA_W-1:0] phi_acc,
    output logic                     busy
);
    typedef enum logic [2:0] {IDLE, FOLD1, ITER1, GAIN, FOLD2, ITER2, DONE} state_t;

    localparam int ATAN [16] = '{51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
                                 256, 128, 64, 32, 16, 8, 4, 2};
    localparam logic signed [INT_W-1:0] HALF_PI = INT_W'(102944);
    localparam logic signed [INT_W:0] OMAX = (INT_W+1)'(2**(DATA_W-1) - 1);
    localparam logic signed [INT_W:0] OMIN = (INT_W+1)'(-(2**(DATA_W-1)));

    state_t                   state;
    logic [3:0]               cnt;
    logic signed [INT_W-1:0]  x, y, z, ax_r, phi_z;
    logic signed [INT_W-1:0]  x_it, y_it, z_it, gain;
    logic                     yz_zero, all_zero;

    function automatic logic signed [INT_W-1:0] sx(input logic signed [DATA_W-1:0] v);
        return {{(INT_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    // z is in 2^-16 rad; round half up to 2^-12 rad and saturate to the output width
    function automatic logic signed [DATA_W-1:0] to_q(input logic signed [INT_W-1:0] v);
        logic signed [INT_W:0] r;
        r = $signed({v[INT_W-1], v} + (INT_W+1)'(8)) >>> 4;
        return (r > OMAX) ? OMAX[DATA_W-1:0] : (r < OMIN) ? OMIN[DATA_W-1:0] : r[DATA_W-1:0];
    endfunction

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign gain     = INT_W'($signed({{(36-INT_W){x[INT_W-1]}}, x} * 36'd19898) >>> 15);

    // one vectoring micro-rotation: drive y toward zero, accumulate the applied angle in z
    always_comb begin
        x_it = !y[INT_W-1] ? x + (y >>> cnt) : x - (y >>> cnt);
        y_it = !y[INT_W-1] ? y - (x >>> cnt) : y + (x >>> cnt);
        z_it = !y[INT_W-1] ? z + INT_W'(ATAN[cnt]) : z - INT_W'(ATAN[cnt]);
    end

    // sequencer: roll pass, gain-correct the magnitude, pitch pass, publish both angles
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            theta_acc <= '0;
            phi_acc   <= '0;
            cnt       <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            ax_r      <= '0;
            phi_z     <= '0;
            yz_zero   <= 1'b0;
            all_zero  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    ax_r     <= sx(ax);
                    x        <= sx(az);
                    y        <= sx(ay);
                    z        <= '0;
                    yz_zero  <= (ay == '0) && (az == '0);
                    all_zero <= (ax == '0) && (ay == '0) && (az == '0);
                    state    <= FOLD1;
                end
                FOLD1: begin
                    if (x[INT_W-1]) begin
                        x <= y[INT_W-1] ? -y : y;
                        y <= y[INT_W-1] ? x : -x;
                        z <= y[INT_W-1] ? -HALF_PI : HALF_PI;
                    end
                    cnt   <= '0;
                    state <= ITER1;
                end
                ITER1, ITER2: begin
                    x     <= x_it;
                    y     <= y_it;
                    z     <= z_it;
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'(ITER-1))
                        state <= (state == ITER1) ? GAIN : DONE;
                end
                GAIN: begin
                    phi_z <= z;
                    x     <= gain;
                    state <= FOLD2;
                end
                FOLD2: begin
                    y     <= -ax_r;
                    z     <= '0;
                    cnt   <= '0;
                    state <= ITER2;
                end
                DONE: begin
                    theta_acc <= all_zero ? '0 : to_q(z);
                    phi_acc   <= yz_zero ? '0 : to_q(phi_z);
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_accel_tilt_cordic.sv
// tb_accel_tilt_cordic: random and directed samples scored against an ideal atan2 model
module tb_accel_tilt_cordic;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic signed [15:0] ax = '0, ay = '0, az = '0;
    logic in_ready, out_valid, busy;
    logic signed [15:0] theta_acc, phi_acc;

    typedef struct { int th; int ph; int cap; } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int pass = 0, total = 0, cyc = 0, npulse = 0;
    logic prev_ov = 1'b0;

    always #5 clk = ~clk;

    accel_tilt_cordic dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ax(ax), .ay(ay), .az(az), .out_valid(out_valid),
        .theta_acc(theta_acc), .phi_acc(phi_acc), .busy(busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp, input int tol);
        int d;
        d = act - exp;
        if (d > 12868) d -= 25736;
        else if (d < -12868) d += 25736;
        total++;
        if (d <= tol && d >= -tol) pass++;
        else $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
    endtask

    task automatic bad(input string name);
        total++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    function automatic int q12(input real r);
        return int'($floor(r * 4096.0 + 0.5));
    endfunction

    function automatic exp_t model(input int x, input int y, input int z, input int cap);
        exp_t e;
        real ry, rz;
        ry = real'(y);
        rz = real'(z);
        e.ph = q12($atan2(ry, rz));
        e.th = q12($atan2(-real'(x), $sqrt(ry * ry + rz * rz)));
        e.cap = cap;
        return e;
    endfunction

    task automatic send(input int x, input int y, input int z);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            bad("ready_wait");
            return;
        end
        ax = 16'(x);
        ay = 16'(y);
        az = 16'(z);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back(model(x, y, z, cyc));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) bad("drain");
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        prev_ov <= out_valid;
        if (!reset && out_valid) begin
            npulse <= npulse + 1;
            chk("pulse_width", int'(prev_ov), 0, 0);
            if (sb.size() == 0) begin
                bad("unexpected_out_valid");
            end else begin
                mon_e = sb.pop_front();
                chk("theta", int'(theta_acc), mon_e.th, 2);
                chk("phi", int'(phi_acc), mon_e.ph, 2);
                chk("latency", cyc - mon_e.cap, 32, 0);
            end
        end
    end

    initial begin
        int rx, ry, rz, cap, n, n0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1, 0);
        chk("rst_busy", int'(busy), 0, 0);
        chk("rst_out_valid", int'(out_valid), 0, 0);
        chk("rst_theta", int'(theta_acc), 0, 0);
        chk("rst_phi", int'(phi_acc), 0, 0);
        reset = 1'b0;

        send(0, 0, 4096);
        send(0, 4096, 4096);
        send(-4096, 0, 4096);
        send(4096, 0, 4096);
        send(0, 0, -4096);
        send(0, -1, -4096);
        send(32767, -32768, -32768);
        send(0, 0, 0);
        send(4096, 0, 0);
        send(-20000, 0, 0);

        for (int k = 0; k < 40; k++) begin
            rx = int'($signed(16'($urandom)));
            if (k % 10 == 0) begin
                ry = 0;
                rz = 0;
                rx = (k % 20 == 0) ? 16384 + int'($urandom_range(16383)) : -16384 - int'($urandom_range(16384));
            end else begin
                do begin
                    ry = int'($signed(16'($urandom)));
                    rz = int'($signed(16'($urandom)));
                end while (longint'(ry) * ry + longint'(rz) * rz < 64'sd268435456);
            end
            send(rx, ry, rz);
        end
        drain();

        @(negedge clk);
        ax = 16'sd3000;
        ay = 16'sd9000;
        az = -16'sd12000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        cap = cyc;
        sb.push_back(model(3000, 9000, -12000, cap));
        repeat (5) @(negedge clk);
        ax = -16'sd7000;
        ay = -16'sd15000;
        az = 16'sd20000;
        sb.push_back(model(-7000, -15000, 20000, cap + 33));
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rearm_cycle", cyc - cap, 32, 0);
        @(posedge clk);
        #1;
        chk("held_recapture_busy", int'(busy), 1, 0);
        in_valid = 1'b0;
        drain();

        send(-5000, 12000, 8000);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", int'(busy), 0, 0);
        chk("abort_in_ready", int'(in_ready), 1, 0);
        chk("abort_out_valid", int'(out_valid), 0, 0);
        chk("abort_theta", int'(theta_acc), 0, 0);
        chk("abort_phi", int'(phi_acc), 0, 0);
        sb.delete();
        reset = 1'b0;
        n0 = npulse;
        repeat (40) @(negedge clk);
        chk("abort_no_pulse", npulse, n0, 0);

        send(-4096, 4096, 4096);
        drain();

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
